// File: rtl/m5_ctrl_pkg.sv
// Shared types and constants for the query arbiter slice.
package m5_ctrl_pkg;

  typedef enum logic [1:0] {
    COUNT = 2'd0,
    REQ   = 2'd1,
    RESP  = 2'd2
  } chan_state_e;

  localparam int DROP_CNT_W = 16;

endpackage

// File: rtl/m5_query_chan.sv
// One tracker channel: event counter, query handshake FSM and a
// one-entry holding register for the returned migration address.
//
// state | meaning
// COUNT | counting events toward the programmed rate
// REQ   | query_en high, waiting for query_ready
// RESP  | waiting for the tracker to hand over an address
import m5_ctrl_pkg::*;

module m5_query_chan #(
  parameter int ADDR_SIZE = 28,
  parameter int RATE_W    = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [RATE_W-1:0]    rate,
  input  logic                 mode,
  input  logic                 mem_chan_rd_en,
  input  logic                 query_ready,
  input  logic                 mig_addr_en,
  input  logic [ADDR_SIZE-1:0] mig_addr,
  input  logic                 grant,
  output logic                 query_en,
  output logic                 mig_addr_ready,
  output logic                 hold_valid,
  output logic [ADDR_SIZE-1:0] hold_addr,
  output logic                 drop
);

  chan_state_e       state, state_nxt;
  logic [RATE_W-1:0] cnt;
  logic [RATE_W:0]   cnt_inc;
  logic              event_hit;
  logic              enabled;
  logic              wrap;
  logic              handshake;

  assign event_hit = mode | mem_chan_rd_en;
  assign enabled   = |rate;
  assign cnt_inc   = {1'b0, cnt} + (RATE_W+1)'(1);
  // >= against the live rate so a lowered rate fires on the next event
  assign wrap      = event_hit & enabled & (cnt_inc >= {1'b0, rate});
  assign handshake = mig_addr_en & mig_addr_ready;
  assign drop      = mig_addr_en & ~mig_addr_ready;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= COUNT;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      COUNT:   if (wrap)        state_nxt = REQ;
      REQ:     if (query_ready) state_nxt = RESP;
      RESP:    if (handshake)   state_nxt = COUNT;
      default:                  state_nxt = COUNT;
    endcase
  end

  // Moore outputs
  always_comb begin
    query_en       = (state == REQ);
    mig_addr_ready = (state == RESP) && !hold_valid;
  end

  // Event counter, held at zero outside COUNT or when disabled
  always_ff @(posedge clk) begin
    if (rst)                              cnt <= '0;
    else if (state != COUNT || !enabled)  cnt <= '0;
    else if (event_hit)                   cnt <= wrap ? '0 : cnt_inc[RATE_W-1:0];
  end

  // Holding register: filled only when empty, emptied by an arbiter grant
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_valid <= 1'b0;
      hold_addr  <= '0;
    end else if (handshake) begin
      hold_valid <= 1'b1;
      hold_addr  <= mig_addr;
    end else if (grant) begin
      hold_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/m5_query_arb.sv
// Query arbiter top: per-channel query FSMs, round-robin merge of the
// holding registers into one output FIFO, and a saturating drop counter.
import m5_ctrl_pkg::*;

module m5_query_arb #(
  parameter int NUM_TRK    = 2,
  parameter int ADDR_SIZE  = 28,
  parameter int RATE_W     = 32,
  parameter int FIFO_DEPTH = 8,
  localparam int TRK_W     = (NUM_TRK > 1) ? $clog2(NUM_TRK) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_TRK*RATE_W-1:0]      rate,
  input  logic [NUM_TRK-1:0]             mode,
  input  logic                           mem_chan_rd_en,
  output logic [NUM_TRK-1:0]             query_en,
  input  logic [NUM_TRK-1:0]             query_ready,
  input  logic [NUM_TRK-1:0]             mig_addr_en,
  input  logic [NUM_TRK*ADDR_SIZE-1:0]   mig_addr,
  output logic [NUM_TRK-1:0]             mig_addr_ready,
  output logic                           out_valid,
  output logic [ADDR_SIZE-1:0]           out_addr,
  output logic [TRK_W-1:0]               out_src,
  input  logic                           out_ready,
  output logic [DROP_CNT_W-1:0]          drop_cnt
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SUM_W = DROP_CNT_W + 4;
  localparam logic [CNT_W-1:0] DEPTH_L   = CNT_W'(FIFO_DEPTH);
  localparam logic [TRK_W:0]   NUM_TRK_L = (TRK_W+1)'(NUM_TRK);
  localparam logic [TRK_W-1:0] LAST_TRK  = TRK_W'(NUM_TRK - 1);

  typedef struct packed {
    logic [TRK_W-1:0]     src;
    logic [ADDR_SIZE-1:0] addr;
  } entry_t;

  logic [NUM_TRK-1:0]   hold_valid;
  logic [ADDR_SIZE-1:0] hold_addr [NUM_TRK];
  logic [NUM_TRK-1:0]   grant;
  logic [NUM_TRK-1:0]   drop;

  entry_t               fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic [CNT_W-1:0]     fifo_cnt;
  logic                 pop, push, push_ok;

  logic [TRK_W-1:0]     rr_ptr;
  logic [TRK_W-1:0]     gnt_idx;
  logic [TRK_W:0]       cand;
  logic [TRK_W-1:0]     cand_idx;
  logic [SUM_W-1:0]     drop_total;

  for (genvar i = 0; i < NUM_TRK; i++) begin : g_chan
    m5_query_chan #(
      .ADDR_SIZE (ADDR_SIZE),
      .RATE_W    (RATE_W)
    ) u_chan (
      .clk            (clk),
      .rst            (rst),
      .rate           (rate[i*RATE_W +: RATE_W]),
      .mode           (mode[i]),
      .mem_chan_rd_en (mem_chan_rd_en),
      .query_ready    (query_ready[i]),
      .mig_addr_en    (mig_addr_en[i]),
      .mig_addr       (mig_addr[i*ADDR_SIZE +: ADDR_SIZE]),
      .grant          (grant[i]),
      .query_en       (query_en[i]),
      .mig_addr_ready (mig_addr_ready[i]),
      .hold_valid     (hold_valid[i]),
      .hold_addr      (hold_addr[i]),
      .drop           (drop[i])
    );
  end

  assign out_valid = (fifo_cnt != '0);
  assign pop       = out_valid & out_ready;
  assign push_ok   = (fifo_cnt < DEPTH_L) | pop;
  assign push      = |grant;
  assign out_addr  = fifo_mem[rd_ptr].addr;
  assign out_src   = fifo_mem[rd_ptr].src;

  // Round-robin pick of one full holding register, searching from rr_ptr
  always_comb begin
    grant    = '0;
    gnt_idx  = '0;
    cand     = '0;
    cand_idx = '0;
    for (int k = NUM_TRK - 1; k >= 0; k--) begin
      cand = {1'b0, rr_ptr} + (TRK_W+1)'(k);
      if (cand >= NUM_TRK_L) cand = cand - NUM_TRK_L;
      cand_idx = cand[TRK_W-1:0];
      // last assignment wins, so the lowest offset from rr_ptr takes priority
      if (push_ok && hold_valid[cand_idx]) begin
        grant   = '0;
        grant[cand_idx] = 1'b1;
        gnt_idx = cand_idx;
      end
    end
  end

  // Pointer moves past the granted channel; holds when nothing is granted
  always_ff @(posedge clk) begin
    if (rst)       rr_ptr <= '0;
    else if (push) rr_ptr <= (gnt_idx == LAST_TRK) ? '0 : gnt_idx + TRK_W'(1);
  end

  // Output FIFO storage, pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= '{src: gnt_idx, addr: hold_addr[gnt_idx]};
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // Sum of refused addresses this cycle added onto the running count
  always_comb begin
    drop_total = {4'b0, drop_cnt};
    for (int k = 0; k < NUM_TRK; k++) drop_total = drop_total + SUM_W'(drop[k]);
  end

  // Saturating drop counter
  always_ff @(posedge clk) begin
    if (rst) drop_cnt <= '0;
    else     drop_cnt <= (drop_total > SUM_W'({DROP_CNT_W{1'b1}})) ? '1
                                                                  : drop_total[DROP_CNT_W-1:0];
  end

endmodule

// File: tb/tb_m5_query_arb.sv
// Bench for m5_query_arb: a queue-based reference model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_m5_query_arb;

  localparam int N  = 2;
  localparam int AW = 28;
  localparam int RW = 32;
  localparam int D  = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [N*RW-1:0]   rate;
  logic [N-1:0]      mode;
  logic              mem_chan_rd_en;
  logic [N-1:0]      query_en;
  logic [N-1:0]      query_ready;
  logic [N-1:0]      mig_addr_en;
  logic [N*AW-1:0]   mig_addr;
  logic [N-1:0]      mig_addr_ready;
  logic              out_valid;
  logic [AW-1:0]     out_addr;
  logic [0:0]        out_src;
  logic              out_ready;
  logic [15:0]       drop_cnt;

  int pass_cnt  = 0;
  int total_cnt = 0;

  m5_query_arb #(.NUM_TRK(N), .ADDR_SIZE(AW), .RATE_W(RW), .FIFO_DEPTH(D)) dut (
    .clk            (clk),
    .rst            (rst),
    .rate           (rate),
    .mode           (mode),
    .mem_chan_rd_en (mem_chan_rd_en),
    .query_en       (query_en),
    .query_ready    (query_ready),
    .mig_addr_en    (mig_addr_en),
    .mig_addr       (mig_addr),
    .mig_addr_ready (mig_addr_ready),
    .out_valid      (out_valid),
    .out_addr       (out_addr),
    .out_src        (out_src),
    .out_ready      (out_ready),
    .drop_cnt       (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  typedef struct { int src; logic [AW-1:0] addr; } ent_t;
  ent_t          m_q[$];
  int            m_ph  [N];   // 0 counting, 1 querying, 2 awaiting address
  longint        m_cnt [N];
  bit            m_hv  [N];
  logic [AW-1:0] m_ha  [N];
  int            m_rr;
  int            m_drop;
  bit            model_live = 1'b0;

  function automatic bit m_rdy(input int i);
    return (m_ph[i] == 2) && !m_hv[i];
  endfunction

  task automatic model_step();
    bit     rdy [N];
    bit     pop, can_push, done;
    int     idx;
    longint r;
    if (rst) begin
      m_q.delete();
      for (int i = 0; i < N; i++) begin
        m_ph[i] = 0; m_cnt[i] = 0; m_hv[i] = 0; m_ha[i] = '0;
      end
      m_rr = 0; m_drop = 0; model_live = 1'b1;
      return;
    end
    for (int i = 0; i < N; i++) rdy[i] = m_rdy(i);
    pop      = (m_q.size() > 0) && out_ready;
    can_push = (m_q.size() < D) || pop;
    for (int i = 0; i < N; i++)
      if (mig_addr_en[i] && !rdy[i] && m_drop < 65535) m_drop++;
    if (pop) void'(m_q.pop_front());
    done = 1'b0;
    if (can_push)
      for (int k = 0; k < N; k++) begin
        idx = (m_rr + k) % N;
        if (!done && m_hv[idx]) begin
          m_q.push_back('{src: idx, addr: m_ha[idx]});
          m_hv[idx] = 1'b0;
          m_rr = (idx + 1) % N;
          done = 1'b1;
        end
      end
    for (int i = 0; i < N; i++) begin
      r = longint'(rate[i*RW +: RW]);
      case (m_ph[i])
        0: if (r == 0) m_cnt[i] = 0;
           else if (mode[i] || mem_chan_rd_en) begin
             if (m_cnt[i] + 1 >= r) begin m_cnt[i] = 0; m_ph[i] = 1; end
             else m_cnt[i]++;
           end
        1: if (query_ready[i]) m_ph[i] = 2;
        default: if (rdy[i] && mig_addr_en[i]) begin
             m_hv[i] = 1'b1;
             m_ha[i] = mig_addr[i*AW +: AW];
             m_ph[i] = 0;
           end
      endcase
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Every-cycle comparison against the model, away from the active edge
  initial forever begin
    logic [N-1:0] e_q, e_r;
    @(negedge clk);
    if (model_live) begin
      for (int i = 0; i < N; i++) begin
        e_q[i] = (m_ph[i] == 1);
        e_r[i] = m_rdy(i);
      end
      chk("cyc_query_en", query_en, e_q);
      chk("cyc_mig_addr_ready", mig_addr_ready, e_r);
      chk("cyc_out_valid", out_valid, m_q.size() > 0);
      chk("cyc_drop_cnt", drop_cnt, m_drop);
      if (m_q.size() > 0) begin
        chk("cyc_out_addr", out_addr, m_q[0].addr);
        chk("cyc_out_src", out_src, m_q[0].src);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst = 1'b1; rate = '0; mode = '0; mem_chan_rd_en = 1'b0;
    query_ready = '0; mig_addr_en = '0; mig_addr = '0; out_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic pulse();
    mem_chan_rd_en = 1'b1; tick();
    mem_chan_rd_en = 1'b0; tick();
  endtask

  task automatic hs(input logic [N-1:0] en, input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    mig_addr = {a1, a0}; mig_addr_en = en; tick();
    mig_addr_en = '0;
  endtask

  task automatic wait_ready(input logic [N-1:0] mask, input int budget, input string name);
    int n = 0;
    while (((mig_addr_ready & mask) != mask) && n < budget) begin
      tick(); n++;
    end
    chk(name, mig_addr_ready & mask, mask);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- directed scenarios ----------------
  initial begin
    reset_dut();
    chk("rst_query_en", query_en, 0);
    chk("rst_mig_addr_ready", mig_addr_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_addr", out_addr, 0);
    chk("rst_out_src", out_src, 0);
    chk("rst_drop_cnt", drop_cnt, 0);

    // rate0=4 counting read pulses; channel 1 disabled
    rate = {32'd0, 32'd4}; mode = 2'b00;
    repeat (3) pulse();
    chk("a_no_query_after_3", query_en, 2'b00);
    mem_chan_rd_en = 1'b1; tick(); mem_chan_rd_en = 1'b0;
    chk("a_query_after_4th", query_en, 2'b01);
    query_ready = 2'b01; tick(); query_ready = '0;
    chk("a_resp_ready", mig_addr_ready, 2'b01);
    chk("a_query_dropped", query_en, 2'b00);
    hs(2'b01, 28'h55, '0);
    chk("a_lat_t1", out_valid, 0);
    tick();
    chk("a_lat_t2_valid", out_valid, 1);
    chk("a_lat_t2_addr", out_addr, 28'h55);
    chk("a_lat_t2_src", out_src, 0);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    chk("a_popped", out_valid, 0);

    // clock-cycle mode, rate1=3, query_ready tied high
    reset_dut();
    rate = {32'd3, 32'd0}; mode = 2'b10; query_ready = 2'b10;
    tick(); tick();
    chk("b_no_query_yet", query_en, 2'b00);
    tick();
    chk("b_query_3rd", query_en, 2'b10);
    tick();
    chk("b_resp", mig_addr_ready, 2'b10);
    hs(2'b10, '0, 28'hABC);
    chk("b_lat_t1", out_valid, 0);
    tick();
    chk("b_lat_t2_valid", out_valid, 1);
    chk("b_lat_t2_addr", out_addr, 28'hABC);
    chk("b_lat_t2_src", out_src, 1);
    tick();
    chk("b_requery_wait", query_en, 2'b00);
    tick();
    chk("b_requery", query_en, 2'b10);

    // collisions and round-robin alternation
    reset_dut();
    rate = {32'd2, 32'd2}; mode = 2'b11; query_ready = 2'b11;
    wait_ready(2'b11, 10, "c_both_resp");
    rate = '0;
    hs(2'b11, 28'h10, 28'h20);
    tick();
    chk("c1_first_addr", out_addr, 28'h10);
    chk("c1_first_src", out_src, 0);
    out_ready = 1'b1; tick();
    chk("c1_second_addr", out_addr, 28'h20);
    chk("c1_second_src", out_src, 1);
    tick();
    chk("c1_empty", out_valid, 0);
    rate = {32'd2, 32'd2};
    wait_ready(2'b11, 10, "c_both_resp2");
    rate = {32'd0, 32'd2};
    hs(2'b01, 28'h30, '0);
    wait_ready(2'b11, 10, "c_ch0_back");
    rate = '0;
    chk("c_solo_drained", out_valid, 0);
    out_ready = 1'b0;
    hs(2'b11, 28'h40, 28'h50);
    tick();
    chk("c2_first_addr", out_addr, 28'h50);
    chk("c2_first_src", out_src, 1);
    out_ready = 1'b1; tick();
    chk("c2_second_addr", out_addr, 28'h40);
    chk("c2_second_src", out_src, 0);
    tick(); out_ready = 1'b0;

    // full FIFO back-pressure and drop counting
    reset_dut();
    rate = {32'd0, 32'd1}; mode = 2'b01; query_ready = 2'b01;
    for (int k = 0; k < 9; k++) begin
      wait_ready(2'b01, 10, "d_fill_ready");
      hs(2'b01, AW'(32'h100 + k), '0);
    end
    repeat (4) tick();
    chk("d_full_valid", out_valid, 1);
    chk("d_blocked_ready", mig_addr_ready, 2'b00);
    chk("d_no_drops_yet", drop_cnt, 0);
    mig_addr = {28'h0, 28'h999}; mig_addr_en = 2'b01;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("d_ready_low", mig_addr_ready, 2'b00);
    end
    mig_addr_en = '0;
    chk("d_drop_5", drop_cnt, 5);
    out_ready = 1'b1;
    for (int k = 0; k < 9; k++) begin
      chk("d_drain_valid", out_valid, 1);
      chk("d_drain_addr", out_addr, 32'h100 + k);
      tick();
    end
    chk("d_drained", out_valid, 0);
    out_ready = 1'b0;

    // reset mid-operation
    reset_dut();
    rate = {32'd0, 32'd1}; mode = 2'b01; query_ready = 2'b01;
    for (int k = 0; k < 3; k++) begin
      wait_ready(2'b01, 10, "e_fill_ready");
      hs(2'b01, AW'(32'h200 + k), '0);
    end
    wait_ready(2'b01, 10, "e_in_resp");
    chk("e_pre_valid", out_valid, 1);
    rst = 1'b1; rate = {32'd0, 32'd3}; tick(); rst = 1'b0;
    chk("e_post_valid", out_valid, 0);
    chk("e_post_query", query_en, 2'b00);
    chk("e_post_ready", mig_addr_ready, 2'b00);
    tick(); tick();
    chk("e_restart_wait", query_en, 2'b00);
    tick();
    chk("e_restart_query", query_en, 2'b01);

    // lowering rate below the current count
    reset_dut();
    rate = {32'd0, 32'd100}; mode = 2'b00;
    repeat (20) pulse();
    chk("f_count_20", query_en, 2'b00);
    rate = {32'd0, 32'd5};
    tick();
    chk("f_no_event", query_en, 2'b00);
    mem_chan_rd_en = 1'b1; tick(); mem_chan_rd_en = 1'b0;
    chk("f_query_after_event", query_en, 2'b01);

    tick();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/m5_query_arb.md
M5_QUERY_ARB -- requirements
Module: m5_query_arb

Interface
REQ-001 Parameter NUM_TRK, 2: number of hot-tracker channels (page, cache, ...); legal range 1..8.
REQ-002 Parameter ADDR_SIZE, 28: migration address width in cache lines.
REQ-003 Parameter RATE_W, 32: width of each rate field.
REQ-004 Parameter FIFO_DEPTH, 8: output FIFO depth; must be a power of two and at least 2.
REQ-005 Port list (name, direction, width, meaning):
- clk, in, 1: sole clock.
- rst, in, 1: synchronous, active-high reset.
- rate, in, NUM_TRK*RATE_W: per-channel query interval; channel i occupies bits [i*RATE_W +: RATE_W].
- mode, in, NUM_TRK: per-channel event source; 0 = mem_chan_rd_en pulses, 1 = clk cycles.
- mem_chan_rd_en, in, 1: memory-channel read event.
- query_en, out, NUM_TRK: query request to tracker i.
- query_ready, in, NUM_TRK: tracker i accepts the query.
- mig_addr_en, in, NUM_TRK: tracker i presents a migration address.
- mig_addr, in, NUM_TRK*ADDR_SIZE: migration addresses, packed the same way as rate.
- mig_addr_ready, out, NUM_TRK: address accepted from tracker i.
- out_valid, out, 1: merged output FIFO is non-empty.
- out_addr, out, ADDR_SIZE: address at the FIFO head.
- out_src, out, TRK_W: source channel of the head entry; TRK_W = max(1, clog2(NUM_TRK)).
- out_ready, in, 1: consumer pops the head entry.
- drop_cnt, out, 16: count of tracker addresses refused; saturates.

Function
REQ-006 Each channel runs an FSM with states COUNT, REQ and RESP.
REQ-007 In COUNT, an event (mem_chan_rd_en=1 in mode 0, or every cycle in mode 1) increments the channel counter. When an event arrives with counter+1 >= rate, the counter clears and the FSM moves to REQ.
REQ-008 A channel with rate==0 is disabled: it stays in COUNT, its counter is held at 0, and it never asserts query_en.
REQ-009 Comparison against the live rate value uses >=, so lowering rate below the current count triggers a query on the next event.
REQ-010 In REQ, query_en[i]=1. When query_en[i] and query_ready[i] are both 1 in the same cycle, the FSM moves to RESP on the next edge.
REQ-011 Events arriving in REQ or RESP are not counted; the counter stays at 0.
REQ-012 In RESP, mig_addr_ready[i]=1 exactly when the channel's one-entry holding register is empty. Handshake = mig_addr_en and mig_addr_ready. On handshake the address loads into the holding register and the FSM returns to COUNT.
REQ-013 Whenever mig_addr_en[i]=1 and mig_addr_ready[i]=0, drop_cnt increments by 1 per cycle per channel, saturating at 16'hFFFF.
REQ-014 A round-robin arbiter grants one full holding register per cycle, starting from the channel after the last grant. A granted entry pushes {src, addr} into the FIFO and clears its holding register.
REQ-015 The FIFO accepts a push when its count < FIFO_DEPTH, or when a pop occurs in the same cycle. Otherwise no grant is issued and the round-robin pointer holds.
REQ-016 Pop occurs when out_valid and out_ready are both 1. Simultaneous push and pop leave the count unchanged. Read and write pointers wrap modulo FIFO_DEPTH.
REQ-017 out_addr and out_src are driven directly from the head entry and are stable while out_valid=1 and out_ready=0.
REQ-018 Latency: with an empty FIFO and no contention, a mig handshake in cycle t gives out_valid=1 in cycle t+2.
REQ-019 The holding register is refilled by a new handshake only once it is empty, so no address is overwritten.

Reset
REQ-020 While rst=1 at a clk edge, all state is cleared:
- all FSMs go to COUNT and all counters to 0;
- holding registers are emptied and FIFO pointers and count go to 0;
- the round-robin pointer goes to 0 and drop_cnt to 0.
REQ-021 Output values in the cycle after reset: query_en=0, mig_addr_ready=0, out_valid=0, out_addr=0, out_src=0, drop_cnt=0.
REQ-022 Reset asserted mid-operation discards pending queries, held addresses and FIFO contents, with no partial output.

Structure
REQ-023 Package m5_ctrl_pkg holds the chan_state_e enum (COUNT, REQ, RESP) and the DROP_CNT_W=16 constant.
REQ-024 The per-channel FSM, counter and holding register live in sub-module m5_query_chan, instantiated NUM_TRK times. The arbiter and FIFO live in m5_query_arb.

Verification
REQ-025 NUM_TRK=2, rate0=4, mode0=0, four mem_chan_rd_en pulses -> query_en[0] rises the cycle after the 4th pulse; query_en[1] stays 0 with rate1=0.
REQ-026 mode1=1, rate1=3, query_ready tied to 1, address 0xABC returned -> query_en[1] every 3 cycles plus the handshake cycles; out_addr=0xABC, out_src=1 at t+2.
REQ-027 Both channels hand over addresses 0x10 and 0x20 in the same cycle -> the two addresses leave in consecutive cycles in round-robin order, and the order alternates on the next collision.
REQ-028 out_ready=0, FIFO filled to 8 entries, then a ninth address offered -> mig_addr_ready stays 0 once the holding register is full, and drop_cnt counts each cycle mig_addr_en stays high.
REQ-029 rst pulsed while channel 0 is in RESP with 3 FIFO entries -> next cycle out_valid=0 and query_en=0, and counting restarts from 0.
REQ-030 rate0 changed from 100 to 5 while the counter is at 20 -> query_en[0] asserts after the next event.
